transceiver_ctrl: RTL and testbench
===================================

Name: transceiver_ctrl

Overview:
- Sequences the serial transceiver and is its only interface to the rest of the design.
- Generates the oversampling clock `sample_clk` from `clk`. Arbitrates two byte requesters onto the single transmitter with round-robin priority.
- Captures each byte completed by the receiver into a one-entry holding register with a valid/ack handshake and an overrun flag.

Parameters:
- SAMPLE_DIV, 5: `clk` cycles per `sample_clk` period. Legal range ≥ 2. The serial bit period is 16 `sample_clk` periods.
- DATA_W, 8: byte width on all data ports.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 wants to send `data0`; held until `grant0`
- data0  in  DATA_W  requester 0 byte
- req1  in  1  requester 1 wants to send `data1`; held until `grant1`
- data1  in  DATA_W  requester 1 byte
- grant0  out  1  one-cycle pulse: `data0` accepted
- grant1  out  1  one-cycle pulse: `data1` accepted
- tx_data  out  DATA_W  byte presented to the transmitter
- tx_en  out  1  one-cycle start pulse to the transmitter
- tx_status  in  1  transmitter idle (1) / busy (0)
- sample_clk  out  1  oversampling clock to transmitter and receiver
- rx_data  in  DATA_W  receiver output byte
- rx_status  in  1  receiver byte-complete flag; rising edge = new byte
- rd_data  out  DATA_W  captured receive byte
- rd_valid  out  1  `rd_data` holds an unread byte
- rd_ack  in  1  consumer read; honoured only while `rd_valid` = 1
- overrun  out  1  sticky: a received byte was dropped

Behaviour:
- Reset (async, active-high): all outputs 0, divider count 0, FSM = IDLE, round-robin pointer favours requester 0, `rx_status` edge register 0.
- Divider:
  - Count runs 0..SAMPLE_DIV-1 and wraps.
  - `sample_clk` = 1 while count < SAMPLE_DIV/2 (integer division), else 0.
  - Registered output, free-running, unaffected by the TX/RX state.
- TX FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if any request is active and `tx_status` = 1, grant one requester.
    - Both requesting: grant the one not granted last. The pointer flips only on a grant.
    - On grant: latch the byte into `tx_data`, pulse the matching grant for that cycle, go to START.
  - START: `tx_en` = 1 for exactly one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_status` = 0, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: stay until `tx_status` = 1, then go to IDLE. The next grant can occur in the cycle after IDLE is entered.
  - `tx_data` holds its value from grant until the next grant.
  - Requests arriving outside IDLE wait. Grant-to-`tx_en` latency is 1 cycle.
- RX capture:
  - A rising edge of `rx_status` (current 1, registered previous 0) is the capture event.
  - Event with `rd_valid` = 0, or with `rd_valid` = 1 and `rd_ack` = 1 in the same cycle: load `rx_data` into `rd_data`, `rd_valid` = 1, `overrun` unchanged.
  - Event with `rd_valid` = 1 and `rd_ack` = 0: byte dropped, `rd_data` unchanged, `overrun` set to 1.
  - `rd_ack` with `rd_valid` = 1 and no event: `rd_valid` and `overrun` cleared next cycle.
  - `rd_ack` with `rd_valid` = 0: ignored.
- Reset mid-transfer: FSM returns to IDLE and any in-flight grant is lost. The transmitter is reset by the same signal.

Decomposition:
- Shared package: TX state encoding (IDLE/START/WAIT_BUSY/WAIT_DONE), the 16x oversample constant, the default DATA_W.
- One natural sub-module: `sample_clk_gen` (the divider). Arbiter, FSM and RX capture stay inline.

Test Plan:
- Reset released, SAMPLE_DIV = 5 → `sample_clk` high 2 `clk` cycles, low 3, repeating; all other outputs 0.
- `req0` with `data0` = 8'hA5, `tx_status` = 1 → `grant0` pulse at cycle N, `tx_data` = 8'hA5 and `tx_en` = 1 at N+1. Model drives `tx_status` 0 for 160 `clk` cycles, then 1 → FSM back to IDLE.
- `req0` and `req1` both held (8'h11, 8'h22) through 4 transfers → grant order 0, 1, 0, 1; `tx_data` sequence 11, 22, 11, 22.
- `rx_status` rises with `rx_data` = 8'b01010111 → `rd_valid` = 1 and `rd_data` = 8'h57 next cycle. `rd_ack` → `rd_valid` = 0.
- Two `rx_status` rising edges (8'h3C, then 8'hC3), no ack → `rd_data` = 8'h3C and `overrun` = 1. Edge coinciding with `rd_ack` → new byte loaded, `overrun` stays 0.
- `reset` asserted during WAIT_DONE → all outputs 0 immediately; after release, a pending `req1` is granted first only if `req0` is absent.

Source files
------------

// File: rtl/transceiver_ctrl_pkg.sv
// Shared types and constants for the serial transceiver controller.
// Imported by the top and the oversample divider.
package transceiver_ctrl_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/transceiver_ctrl_sample_clk_gen.sv
// Free-running divider producing the oversampling clock.
// High for the first SAMPLE_DIV/2 counts of every period.
module sample_clk_gen
  import transceiver_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV = 5
) (
  input  logic clk,
  input  logic reset,
  output logic sample_clk_o
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(SAMPLE_DIV / 2);

  logic [CW-1:0] count_q, count_d;
  logic          sclk_q;

  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q == LAST) count_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sclk_q  <= (count_q < HALF);
    end
  end

  assign sample_clk_o = sclk_q;

endmodule

// File: rtl/transceiver_ctrl.sv
// Transceiver sequencer: round-robin TX arbitration and FSM,
// oversample clock, and a one-entry RX holding register.
module transceiver_ctrl
  import transceiver_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV = 5,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              grant0,
  output logic              grant1,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_en,
  input  logic              tx_status,
  output logic              sample_clk,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_status,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ack,
  output logic              overrun
);

  tx_state_e         state_q, state_d;
  logic              prio_q, prio_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              tx_en_q, tx_en_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              pick;

  logic              rxs_q;
  logic              rx_evt;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovr_q, ovr_d;

  sample_clk_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sclk (
    .clk         (clk),
    .reset       (reset),
    .sample_clk_o(sample_clk)
  );

  // prio_q = 1 favours requester 1 when both request
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    grant0_d  = 1'b0;
    grant1_d  = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    pick      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((req0 || req1) && tx_status) begin
          pick      = (req0 && req1) ? prio_q : req1;
          grant0_d  = !pick;
          grant1_d  = pick;
          tx_data_d = pick ? data1 : data0;
          prio_d    = !pick;
          state_d   = START;
        end
      end
      START: begin
        tx_en_d = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (!tx_status) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_status) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign rx_evt = rx_status && !rxs_q;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    ovr_d      = ovr_q;
    if (rx_evt) begin
      if (!rd_valid_q || rd_ack) begin
        rd_data_d  = rx_data;
        rd_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_ack && rd_valid_q) begin
      rd_valid_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      rxs_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      rxs_q      <= rx_status;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign grant0   = grant0_q;
  assign grant1   = grant1_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_transceiver_ctrl.sv
// Directed bench for transceiver_ctrl: divider, arbitration,
// TX handshake, RX capture/overrun and mid-transfer reset.
module tb_transceiver_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       grant0, grant1;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_status;
  logic       sample_clk;
  logic [7:0] rx_data;
  logic       rx_status;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ack;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  transceiver_ctrl #(
    .SAMPLE_DIV(5),
    .DATA_W    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .grant0    (grant0),
    .grant1    (grant1),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_status (tx_status),
    .sample_clk(sample_clk),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ack    (rd_ack),
    .overrun   (overrun)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    tx_status = 1'b1;
  endtask

  // Waits for a grant, checks it, then plays the transmitter.
  task automatic xfer(input int lat, input bit g1,
                      input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(grant0 || grant1) && n < 20);
    checks++;
    if (!(grant0 || grant1)) begin
      errors++;
      $display("FAIL grant_timeout got=none exp=grant%0d", g1);
      return;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL grant_latency got=%0d exp=%0d", n, lat);
    end
    checks++;
    if ({grant1, grant0} !== (g1 ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant_sel got=%b exp=%b", {grant1, grant0},
               g1 ? 2'b10 : 2'b01);
    end
    if (!hold) begin
      if (g1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({tx_en, tx_data, grant0, grant1} !== {1'b1, d, 2'b00}) begin
      errors++;
      $display("FAIL tx_start got=en%b d%h g%b%b exp=en1 d%h g00",
               tx_en, tx_data, grant0, grant1, d);
    end
    tx_status = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b0 || tx_data !== d) begin
      errors++;
      $display("FAIL tx_en_pulse got=en%b d%h exp=en0 d%h",
               tx_en, tx_data, d);
    end
    repeat (159) @(negedge clk);
    tx_status = 1'b1;
  endtask

  task automatic test_reset();
    logic exp;
    reset = 1'b1;
    req0 = 0; req1 = 0; data0 = 0; data1 = 0;
    tx_status = 1'b1;
    rx_data = 0; rx_status = 0; rd_ack = 0;
    @(negedge clk);
    checks++;
    if ({grant0, grant1, tx_en, tx_data, sample_clk,
         rd_data, rd_valid, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {grant0, grant1, tx_en, tx_data, sample_clk,
                rd_data, rd_valid, overrun});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp = ((i % 5) < 2);
      checks++;
      if (sample_clk !== exp) begin
        errors++;
        $display("FAIL sample_clk[%0d] got=%b exp=%b", i, sample_clk, exp);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0  = 1'b1;
    data0 = 8'hA5;
    xfer(1, 1'b0, 8'hA5, 1'b0);
    req1  = 1'b1;
    data1 = 8'h5B;
    xfer(2, 1'b1, 8'h5B, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'h22;
    xfer(1, 1'b0, 8'h11, 1'b1);
    xfer(2, 1'b1, 8'h22, 1'b1);
    xfer(2, 1'b0, 8'h11, 1'b1);
    xfer(2, 1'b1, 8'h22, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_rx();
    @(negedge clk);
    rx_data = 8'b01010111; rx_status = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data, overrun} !== {1'b1, 8'h57, 1'b0}) begin
      errors++;
      $display("FAIL rx_capture got=v%b d%h o%b exp=v1 d57 o0",
               rd_valid, rd_data, overrun);
    end
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_ack got=v%b exp=v0", rd_valid);
    end
    rx_status = 1'b0;
    @(negedge clk);
    rx_data = 8'h3C; rx_status = 1'b1;
    @(negedge clk);
    rx_status = 1'b0;
    @(negedge clk);
    rx_data = 8'hC3; rx_status = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data, overrun} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL rx_overrun got=v%b d%h o%b exp=v1 d3c o1",
               rd_valid, rd_data, overrun);
    end
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    rx_status = 1'b0;
    checks++;
    if ({rd_valid, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL rx_ack_clear got=v%b o%b exp=v0 o0",
               rd_valid, overrun);
    end
    @(negedge clk);
    rx_data = 8'h5A; rx_status = 1'b1;
    @(negedge clk);
    rx_status = 1'b0;
    @(negedge clk);
    rx_data = 8'h77; rx_status = 1'b1; rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    checks++;
    if ({rd_valid, rd_data, overrun} !== {1'b1, 8'h77, 1'b0}) begin
      errors++;
      $display("FAIL rx_ack_edge got=v%b d%h o%b exp=v1 d77 o0",
               rd_valid, rd_data, overrun);
    end
    rx_status = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req0 = 1'b1; data0 = 8'hA5;
    data1 = 8'h6E;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    tx_status = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL mid_tx_data got=%h exp=a5", tx_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({grant0, grant1, tx_en, tx_data, sample_clk,
         rd_data, rd_valid, overrun} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b exp=0",
               {grant0, grant1, tx_en, tx_data, sample_clk,
                rd_data, rd_valid, overrun});
    end
    tx_status = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant1, grant0, tx_data} !== {2'b01, 8'hA5}) begin
      errors++;
      $display("FAIL rst_both_grant got=g%b%b d%h exp=g01 da5",
               grant1, grant0, tx_data);
    end
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant1, grant0, tx_data} !== {2'b10, 8'h6E}) begin
      errors++;
      $display("FAIL rst_req1_grant got=g%b%b d%h exp=g10 d6e",
               grant1, grant0, tx_data);
    end
    req1 = 1'b0;
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rx();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
